// File: rtl/serial_unary_reduce.sv
// Serial unary reducer: folds an N-bit operand arriving W bits per beat into AND/OR/XOR/NAND.
// Optional framing check (s_last / sticky err) enabled by UNARY_SERIAL_FRAMING_CHECK_EN.
module serial_unary_reduce #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   op,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_c
`ifdef UNARY_SERIAL_FRAMING_CHECK_EN
  ,
  input  logic         s_last,
  output logic         err
`endif
);

  localparam int unsigned Beats = N / W;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  localparam logic [1:0] OpAnd  = 2'b00;
  localparam logic [1:0] OpOr   = 2'b01;
  localparam logic [1:0] OpXor  = 2'b10;
  localparam logic [1:0] OpNand = 2'b11;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            acc_q;
  logic [1:0]      op_q;
  logic            m_valid_q;
  logic            m_c_q;

  logic            beat_acc;
  logic [1:0]      eff_op;
  logic            beat_red;
  logic            acc_d;
  logic            is_last;
  logic            res_d;

  assign s_ready = (state_q != StDone) && rst_n;
  assign m_valid = m_valid_q;
  assign m_c     = m_c_q;

  always_comb begin
    beat_acc = s_valid && s_ready;
    // op is only taken from the port on the first beat; later beats use the latched copy
    eff_op   = (state_q == StIdle) ? op : op_q;
    case (eff_op)
      OpOr:    beat_red = |s_data;
      OpXor:   beat_red = ^s_data;
      default: beat_red = &s_data;
    endcase
    acc_d = beat_red;
    if (state_q != StIdle) begin
      case (op_q)
        OpOr:    acc_d = acc_q | beat_red;
        OpXor:   acc_d = acc_q ^ beat_red;
        default: acc_d = acc_q & beat_red;
      endcase
    end
    is_last = (cnt_q == LastCnt);
    res_d   = acc_d ^ (eff_op == OpNand);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      op_q      <= OpAnd;
      m_valid_q <= 1'b0;
      m_c_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (beat_acc) begin
            if (state_q == StIdle) begin
              op_q <= op;
            end
            acc_q <= acc_d;
            if (is_last) begin
              cnt_q     <= '0;
              state_q   <= StDone;
              m_valid_q <= 1'b1;
              m_c_q     <= res_d;
            end else begin
              cnt_q   <= cnt_q + CntW'(1);
              state_q <= StAccum;
            end
          end
        end
        StDone: begin
          if (m_ready) begin
            state_q   <= StIdle;
            m_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef UNARY_SERIAL_FRAMING_CHECK_EN
  logic err_q;
  assign err = err_q;

  // Sticky: s_last must coincide exactly with the count-defined final beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (beat_acc && (s_last != is_last)) begin
      err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_unary_reduce.sv
// Directed bench for serial_unary_reduce (N=32, W=8); covers framing check when
// UNARY_SERIAL_FRAMING_CHECK_EN is defined.
module tb_serial_unary_reduce;

  logic       clk;
  logic       rst_n;
  logic [1:0] op;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_c;
`ifdef UNARY_SERIAL_FRAMING_CHECK_EN
  logic       s_last;
  logic       err;
`endif

  int total;
  int bad;

  serial_unary_reduce #(
    .N(32),
    .W(8)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (op),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_c     (m_c)
`ifdef UNARY_SERIAL_FRAMING_CHECK_EN
    ,
    .s_last  (s_last),
    .err     (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends four beats of v (beat k = v[8k+:8]); op is scrambled after the first beat.
  // gap idle cycles are inserted after beat index 1; last_at marks where s_last is driven.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] v,
                        input int gap, input int last_at);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_nostale"}, {31'd0, m_valid}, 32'd0);
      s_valid = 1'b1;
      s_data  = v[k*8 +: 8];
      op      = (k == 0) ? o : ~o;
`ifdef UNARY_SERIAL_FRAMING_CHECK_EN
      s_last  = (k == last_at);
`endif
      tick();
      if (k == 1 && gap > 0) begin
        s_valid = 1'b0;
        s_data  = 8'h5A;
        for (int g = 0; g < gap; g++) begin
          tick();
        end
        check({tag, "_gap_mvalid"}, {31'd0, m_valid}, 32'd0);
        check({tag, "_gap_sready"}, {31'd0, s_ready}, 32'd1);
      end
    end
    s_valid = 1'b0;
`ifdef UNARY_SERIAL_FRAMING_CHECK_EN
    s_last  = 1'b0;
`endif
  endtask

  // Check result presented, consume it with m_ready already high, check release
  task automatic expect_result(input string tag, input logic exp_c);
    check({tag, "_mvalid"}, {31'd0, m_valid}, 32'd1);
    check({tag, "_mc"}, {31'd0, m_c}, {31'd0, exp_c});
    check({tag, "_sready_done"}, {31'd0, s_ready}, 32'd0);
    tick();
    check({tag, "_mvalid_drop"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_sready_back"}, {31'd0, s_ready}, 32'd1);
    check({tag, "_mc_hold"}, {31'd0, m_c}, {31'd0, exp_c});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    op      = 2'b00;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b1;
`ifdef UNARY_SERIAL_FRAMING_CHECK_EN
    s_last  = 1'b0;
`endif
    tick();
    tick();
    check("rst_mvalid", {31'd0, m_valid}, 32'd0);
    check("rst_mc", {31'd0, m_c}, 32'd0);
    check("rst_sready", {31'd0, s_ready}, 32'd0);
`ifdef UNARY_SERIAL_FRAMING_CHECK_EN
    check("rst_err", {31'd0, err}, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rel_sready", {31'd0, s_ready}, 32'd1);

    run_op("and_ones", 2'b00, 32'hFFFF_FFFF, 0, 3);
    expect_result("and_ones", 1'b1);

    run_op("and_fe", 2'b00, 32'hFFFE_FFFF, 0, 3);
    expect_result("and_fe", 1'b0);

    run_op("nand_fe", 2'b11, 32'hFFFE_FFFF, 0, 3);
    expect_result("nand_fe", 1'b1);

    run_op("nand_ones", 2'b11, 32'hFFFF_FFFF, 0, 3);
    expect_result("nand_ones", 1'b0);

    run_op("xor_odd", 2'b10, 32'h0300_0001, 0, 3);
    expect_result("xor_odd", 1'b1);

    run_op("xor_zero", 2'b10, 32'h0000_0000, 0, 3);
    expect_result("xor_zero", 1'b0);

    run_op("or_zero", 2'b01, 32'h0000_0000, 0, 3);
    expect_result("or_zero", 1'b0);
`ifdef UNARY_SERIAL_FRAMING_CHECK_EN
    check("good_frames_err", {31'd0, err}, 32'd0);
`endif

    // Gap of 3 between beats 2 and 3, then 5 cycles of backpressure
    m_ready = 1'b0;
    run_op("or_bp", 2'b01, 32'h0080_0000, 3, 3);
    for (int i = 0; i < 5; i++) begin
      check("bp_mvalid", {31'd0, m_valid}, 32'd1);
      check("bp_mc", {31'd0, m_c}, 32'd1);
      check("bp_sready", {31'd0, s_ready}, 32'd0);
      tick();
    end
    m_ready = 1'b1;
    expect_result("or_bp", 1'b1);

    // Reset after 2 of 4 beats discards the partial operand
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1;
      s_data  = 8'h00;
      op      = 2'b01;
      tick();
    end
    s_valid = 1'b0;
    rst_n   = 1'b0;
    tick();
    check("midrst_mvalid", {31'd0, m_valid}, 32'd0);
    check("midrst_sready", {31'd0, s_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("midrst_rel_sready", {31'd0, s_ready}, 32'd1);
    run_op("post_rst", 2'b00, 32'hFFFF_FFFF, 0, 3);
    expect_result("post_rst", 1'b1);

    // Reset while a result is pending in DONE
    m_ready = 1'b0;
    run_op("pend", 2'b01, 32'h0000_0100, 0, 3);
    check("pend_mvalid", {31'd0, m_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("donerst_mvalid", {31'd0, m_valid}, 32'd0);
    check("donerst_mc", {31'd0, m_c}, 32'd0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    #1;

`ifdef UNARY_SERIAL_FRAMING_CHECK_EN
    // Early s_last on beat 2 sets the sticky error; result still follows the count
    run_op("early_last", 2'b00, 32'hFFFF_FFFF, 0, 1);
    check("early_last_err", {31'd0, err}, 32'd1);
    expect_result("early_last", 1'b1);
    run_op("after_err", 2'b01, 32'h0000_0000, 0, 3);
    expect_result("after_err", 1'b0);
    check("err_sticky", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("err_cleared", {31'd0, err}, 32'd0);
    // Missing s_last on the final beat also flags
    run_op("no_last", 2'b10, 32'h0000_0001, 0, 7);
    expect_result("no_last", 1'b1);
    check("no_last_err", {31'd0, err}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
